// File: rtl/tl_pkg.sv
// Shared constants for the traffic light monitor: lamp codes, phase and fault
// encodings, and monitor state encodings.
package tl_pkg;

  localparam logic [2:0] LAMP_G = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_R = 3'b001;

  localparam logic [1:0] PH_G = 2'b00;
  localparam logic [1:0] PH_Y = 2'b01;
  localparam logic [1:0] PH_R = 2'b10;

  localparam logic [2:0] F_NONE    = 3'd0;
  localparam logic [2:0] F_ILLEGAL = 3'd1;
  localparam logic [2:0] F_ORDER   = 3'd2;
  localparam logic [2:0] F_SHORT   = 3'd3;
  localparam logic [2:0] F_LONG    = 3'd4;

  typedef enum logic [2:0] {
    ST_SYNC   = 3'd0,
    ST_GREEN  = 3'd1,
    ST_YELLOW = 3'd2,
    ST_RED    = 3'd3,
    ST_FAULT  = 3'd4
  } mon_state_t;

  function automatic logic [1:0] next_phase(input logic [1:0] ph);
    case (ph)
      PH_G:    return PH_Y;
      PH_Y:    return PH_R;
      default: return PH_G;
    endcase
  endfunction

  function automatic mon_state_t phase_state(input logic [1:0] ph);
    case (ph)
      PH_G:    return ST_GREEN;
      PH_Y:    return ST_YELLOW;
      default: return ST_RED;
    endcase
  endfunction

  // Minimum-dwell bound: a zero or negative window would accept instant changes.
  function automatic int floor1(input int v);
    return (v < 1) ? 1 : v;
  endfunction

endpackage

// File: rtl/tl_lamp_decode.sv
// One-hot lamp bus decoder: maps a legal code to its phase, flags anything else.
module tl_lamp_decode
  import tl_pkg::*;
(
  input  logic [2:0] lamp,
  output logic [1:0] phase,
  output logic       illegal
);

  always_comb begin
    phase   = PH_G;
    illegal = 1'b0;
    case (lamp)
      LAMP_G:  phase = PH_G;
      LAMP_Y:  phase = PH_Y;
      LAMP_R:  phase = PH_R;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// Watches the controller's lamp bus, checks phase order and dwell, latches the
// first fault and counts completed G->Y->R->G cycles.
//
//  state  | meaning
//  SYNC   | waiting for green to align with the light cycle
//  GREEN  | green observed, dwell counting
//  YELLOW | yellow observed, dwell counting
//  RED    | red observed, dwell counting
//  FAULT  | first fault latched, outputs frozen until clear
module traffic_light_monitor
  import tl_pkg::*;
#(
  parameter int GREEN_LEN  = 6,
  parameter int YELLOW_LEN = 2,
  parameter int RED_LEN    = 5,
  parameter int TOL        = 0,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       lamp,
  input  logic             clear,
  output logic [1:0]       phase,
  output logic             phase_valid,
  output logic [CNT_W-1:0] dwell,
  output logic             fault,
  output logic [2:0]       fault_code,
  output logic             cycle_done,
  output logic [15:0]      cycle_count
);

  localparam logic [CNT_W-1:0] G_MIN = CNT_W'(floor1(GREEN_LEN - TOL));
  localparam logic [CNT_W-1:0] Y_MIN = CNT_W'(floor1(YELLOW_LEN - TOL));
  localparam logic [CNT_W-1:0] R_MIN = CNT_W'(floor1(RED_LEN - TOL));
  localparam logic [CNT_W-1:0] G_MAX = CNT_W'(GREEN_LEN + TOL);
  localparam logic [CNT_W-1:0] Y_MAX = CNT_W'(YELLOW_LEN + TOL);
  localparam logic [CNT_W-1:0] R_MAX = CNT_W'(RED_LEN + TOL);

  mon_state_t       state;
  logic [2:0]       lamp_q;
  logic             primed;
  logic [1:0]       q_ph;
  logic             q_illegal;
  logic [1:0]       cur_ph;
  logic [CNT_W-1:0] cur_min;
  logic [CNT_W-1:0] cur_max;
  logic [CNT_W-1:0] dwell_inc;
  logic [2:0]       eval_code;

  tl_lamp_decode u_decode (
    .lamp    (lamp_q),
    .phase   (q_ph),
    .illegal (q_illegal)
  );

  // Fault classification; the if-chain order gives illegal > order > short > long.
  always_comb begin
    cur_ph  = PH_G;
    cur_min = G_MIN;
    cur_max = G_MAX;
    case (state)
      ST_YELLOW: begin cur_ph = PH_Y; cur_min = Y_MIN; cur_max = Y_MAX; end
      ST_RED:    begin cur_ph = PH_R; cur_min = R_MIN; cur_max = R_MAX; end
      default:   ;
    endcase
    dwell_inc = (dwell == '1) ? dwell : dwell + CNT_W'(1);
    eval_code = F_NONE;
    if (q_illegal) begin
      eval_code = F_ILLEGAL;
    end else if (state inside {ST_GREEN, ST_YELLOW, ST_RED}) begin
      if (q_ph == cur_ph) begin
        if (dwell == cur_max) eval_code = F_LONG;
      end else if (q_ph != next_phase(cur_ph)) begin
        eval_code = F_ORDER;
      end else if (dwell < cur_min) begin
        eval_code = F_SHORT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_SYNC;
      lamp_q      <= 3'b000;
      primed      <= 1'b0;
      phase       <= PH_G;
      phase_valid <= 1'b0;
      dwell       <= '0;
      fault       <= 1'b0;
      fault_code  <= F_NONE;
      cycle_done  <= 1'b0;
      cycle_count <= 16'd0;
    end else begin
      lamp_q     <= lamp;
      cycle_done <= 1'b0;
      if (!primed) begin
        primed <= 1'b1;
      end else if (state == ST_FAULT) begin
        if (clear) begin
          state      <= ST_SYNC;
          fault      <= 1'b0;
          fault_code <= F_NONE;
          dwell      <= '0;
          phase      <= PH_G;
        end
      end else if (eval_code != F_NONE) begin
        state       <= ST_FAULT;
        fault       <= 1'b1;
        fault_code  <= eval_code;
        phase_valid <= 1'b0;
      end else if (state == ST_SYNC) begin
        if (q_ph == PH_G) begin
          state       <= ST_GREEN;
          phase       <= PH_G;
          phase_valid <= 1'b1;
          dwell       <= CNT_W'(1);
        end
      end else if (q_ph == cur_ph) begin
        dwell <= dwell_inc;
      end else begin
        state <= phase_state(q_ph);
        phase <= q_ph;
        dwell <= CNT_W'(1);
        if (q_ph == PH_G) begin
          cycle_done <= 1'b1;
          if (cycle_count != 16'hFFFF) cycle_count <= cycle_count + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Testbench for traffic_light_monitor: directed scenarios plus a randomized run
// against a cycle-level reference model of the monitor's rules.
module tb_traffic_light_monitor;
  localparam int GREEN_LEN  = 6;
  localparam int YELLOW_LEN = 2;
  localparam int RED_LEN    = 5;
  localparam int TOL        = 0;
  localparam int CNT_W      = 8;
  localparam logic [2:0] G = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] R = 3'b001;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             clear = 1'b0;
  logic [2:0]       lamp = 3'b000;
  logic [1:0]       phase;
  logic             phase_valid;
  logic [CNT_W-1:0] dwell;
  logic             fault;
  logic [2:0]       fault_code;
  logic             cycle_done;
  logic [15:0]      cycle_count;

  int total = 0;
  int bad = 0;

  traffic_light_monitor #(
    .GREEN_LEN(GREEN_LEN), .YELLOW_LEN(YELLOW_LEN), .RED_LEN(RED_LEN),
    .TOL(TOL), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .lamp(lamp), .clear(clear),
    .phase(phase), .phase_valid(phase_valid), .dwell(dwell),
    .fault(fault), .fault_code(fault_code),
    .cycle_done(cycle_done), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0=waiting for green, 1=tracking, 2=faulted.
  int   lens [3] = '{GREEN_LEN, YELLOW_LEN, RED_LEN};
  int   m_mode = 0, m_ph = 0, m_dwell = 0, m_code = 0, m_count = 0;
  bit   m_done = 1'b0, m_primed = 1'b0;
  logic [2:0] m_q = 3'b000;
  logic [2:0] sq [$];

  function automatic int lamp_idx(input logic [2:0] l);
    case (l)
      3'b100:  return 0;
      3'b010:  return 1;
      3'b001:  return 2;
      default: return -1;
    endcase
  endfunction

  task automatic model_edge(input logic r, input logic [2:0] l, input logic c);
    int p;
    logic [2:0] seen;
    m_done = 1'b0;
    if (!r) begin
      m_mode = 0; m_ph = 0; m_dwell = 0; m_code = 0; m_count = 0;
      m_primed = 1'b0; m_q = 3'b000;
      return;
    end
    seen = m_q;
    m_q  = l;
    if (!m_primed) begin
      m_primed = 1'b1;
      return;
    end
    if (m_mode == 2) begin
      if (c) begin m_mode = 0; m_code = 0; m_dwell = 0; end
      return;
    end
    p = lamp_idx(seen);
    if (p < 0) begin
      m_mode = 2; m_code = 1;
    end else if (m_mode == 0) begin
      if (p == 0) begin m_mode = 1; m_ph = 0; m_dwell = 1; end
    end else if (p == m_ph) begin
      if (m_dwell == lens[p] + TOL) begin m_mode = 2; m_code = 4; end
      else if (m_dwell < (1 << CNT_W) - 1) m_dwell++;
    end else if (p != (m_ph + 1) % 3) begin
      m_mode = 2; m_code = 2;
    end else if (m_dwell < ((lens[m_ph] - TOL < 1) ? 1 : lens[m_ph] - TOL)) begin
      m_mode = 2; m_code = 3;
    end else begin
      m_ph = p; m_dwell = 1;
      if (p == 0) begin
        m_done = 1'b1;
        if (m_count < 65535) m_count++;
      end
    end
  endtask

  task automatic step(input logic [2:0] l, input logic c = 1'b0, input logic r = 1'b1);
    lamp = l; clear = c; reset = r;
    @(posedge clk);
    model_edge(r, l, c);
    @(negedge clk);
  endtask

  task automatic sq_add(input logic [2:0] l, input int n);
    for (int i = 0; i < n; i++) sq.push_back(l);
  endtask

  // Plays sq plus one pad step, so every entry of sq has been evaluated.
  task automatic play();
    foreach (sq[i]) step(sq[i]);
    step(sq[sq.size()-1]);
    sq.delete();
  endtask

  task automatic do_reset();
    step(G, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    step(3'b000, 1'b0, 1'b0);
    step(3'b000, 1'b0, 1'b0);
    total++; if (phase !== 2'b00) begin bad++; $display("FAIL reset_phase got=%0d exp=0", phase); end
    total++; if (phase_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0d exp=0", phase_valid); end
    total++; if (dwell !== '0) begin bad++; $display("FAIL reset_dwell got=%0d exp=0", dwell); end
    total++; if (fault !== 1'b0) begin bad++; $display("FAIL reset_fault got=%0d exp=0", fault); end
    total++; if (fault_code !== 3'd0) begin bad++; $display("FAIL reset_code got=%0d exp=0", fault_code); end
    total++; if (cycle_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0d exp=0", cycle_done); end
    total++; if (cycle_count !== 16'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", cycle_count); end
  endtask

  task automatic test_normal_cycles();
    int pulses = 0;
    int n;
    logic [2:0] l;
    do_reset();
    for (int k = 0; k < 3; k++) begin sq_add(G, 6); sq_add(Y, 2); sq_add(R, 5); end
    sq_add(G, 1);
    n = sq.size();
    for (int i = 0; i <= n; i++) begin
      l = (i < n) ? sq[i] : G;
      step(l);
      if (cycle_done === 1'b1) pulses++;
      if (i == 1 || (i > 1 && sq[i-1] != sq[i-2])) begin
        total++;
        if (dwell !== CNT_W'(1) || phase !== 2'(lamp_idx(sq[i-1])) || phase_valid !== 1'b1) begin
          bad++;
          $display("FAIL entry_%0d got dwell=%0d phase=%0d valid=%0d exp dwell=1 phase=%0d valid=1",
                   i, dwell, phase, phase_valid, lamp_idx(sq[i-1]));
        end
      end
    end
    sq.delete();
    total++; if (pulses != 3) begin bad++; $display("FAIL normal_pulses got=%0d exp=3", pulses); end
    total++; if (cycle_count !== 16'd3) begin bad++; $display("FAIL normal_count got=%0d exp=3", cycle_count); end
    total++; if (fault !== 1'b0) begin bad++; $display("FAIL normal_fault got=%0d exp=0", fault); end
  endtask

  task automatic test_illegal();
    do_reset();
    step(G); step(G); step(G);
    step(3'b110);
    total++; if (fault !== 1'b0) begin bad++; $display("FAIL illegal_early got=%0d exp=0", fault); end
    step(G);
    total++; if (fault !== 1'b1 || fault_code !== 3'd1 || phase_valid !== 1'b0) begin
      bad++; $display("FAIL illegal_hit got fault=%0d code=%0d valid=%0d exp 1 1 0", fault, fault_code, phase_valid);
    end
    for (int i = 0; i < 6; i++) step((i % 3 == 0) ? G : ((i % 3 == 1) ? Y : R));
    total++; if (fault !== 1'b1 || fault_code !== 3'd1) begin
      bad++; $display("FAIL illegal_sticky got fault=%0d code=%0d exp 1 1", fault, fault_code);
    end
    total++; if (dwell !== CNT_W'(3) || cycle_count !== 16'd0 || cycle_done !== 1'b0) begin
      bad++; $display("FAIL illegal_frozen got dwell=%0d count=%0d done=%0d exp 3 0 0", dwell, cycle_count, cycle_done);
    end
  endtask

  task automatic test_order_dwell();
    do_reset(); sq_add(G, 6); sq_add(R, 1); play();
    total++; if (fault_code !== 3'd2) begin bad++; $display("FAIL order_code got=%0d exp=2", fault_code); end
    do_reset(); sq_add(G, 6); sq_add(Y, 1); sq_add(R, 1); play();
    total++; if (fault_code !== 3'd3) begin bad++; $display("FAIL short_code got=%0d exp=3", fault_code); end
    do_reset(); sq_add(G, 6); play();
    total++; if (fault !== 1'b0 || dwell !== CNT_W'(6)) begin
      bad++; $display("FAIL long_edge got fault=%0d dwell=%0d exp 0 6", fault, dwell);
    end
    do_reset(); sq_add(G, 7); play();
    total++; if (fault_code !== 3'd4 || dwell !== CNT_W'(6)) begin
      bad++; $display("FAIL long_code got code=%0d dwell=%0d exp 4 6", fault_code, dwell);
    end
  endtask

  task automatic test_clear();
    do_reset(); sq_add(G, 6); sq_add(Y, 2); sq_add(R, 5); sq_add(G, 1); sq_add(3'b000, 1); play();
    total++; if (fault_code !== 3'd1 || cycle_count !== 16'd1) begin
      bad++; $display("FAIL clear_setup got code=%0d count=%0d exp 1 1", fault_code, cycle_count);
    end
    step(R, 1'b1);
    total++; if (fault !== 1'b0 || fault_code !== 3'd0 || phase_valid !== 1'b0) begin
      bad++; $display("FAIL clear_exit got fault=%0d code=%0d valid=%0d exp 0 0 0", fault, fault_code, phase_valid);
    end
    step(R); step(R);
    total++; if (fault !== 1'b0 || phase_valid !== 1'b0 || dwell !== '0) begin
      bad++; $display("FAIL clear_sync got fault=%0d valid=%0d dwell=%0d exp 0 0 0", fault, phase_valid, dwell);
    end
    step(G); step(G);
    total++; if (phase_valid !== 1'b1 || dwell !== CNT_W'(1) || phase !== 2'b00 || cycle_count !== 16'd1) begin
      bad++; $display("FAIL clear_resync got valid=%0d dwell=%0d phase=%0d count=%0d exp 1 1 0 1",
                      phase_valid, dwell, phase, cycle_count);
    end
    step(3'b110); step(G, 1'b1);
    total++; if (fault !== 1'b1 || fault_code !== 3'd1) begin
      bad++; $display("FAIL fault_beats_clear got fault=%0d code=%0d exp 1 1", fault, fault_code);
    end
    step(G);
    total++; if (fault !== 1'b1) begin bad++; $display("FAIL clear_outside got=%0d exp=1", fault); end
  endtask

  task automatic test_mid_reset();
    do_reset(); sq_add(G, 6); sq_add(Y, 2); sq_add(R, 5); sq_add(G, 6); sq_add(Y, 2); sq_add(R, 2); play();
    total++; if (cycle_count !== 16'd1 || phase !== 2'b10) begin
      bad++; $display("FAIL midrst_setup got count=%0d phase=%0d exp 1 2", cycle_count, phase);
    end
    step(R, 1'b0, 1'b0);
    total++; if ({phase, phase_valid, dwell, fault, fault_code, cycle_done, cycle_count} !== '0) begin
      bad++; $display("FAIL midrst_zero got phase=%0d valid=%0d dwell=%0d fault=%0d code=%0d count=%0d exp all 0",
                      phase, phase_valid, dwell, fault, fault_code, cycle_count);
    end
    step(R);
    total++; if (fault !== 1'b0) begin bad++; $display("FAIL midrst_primed got=%0d exp=0", fault); end
    step(R);
    total++; if (fault !== 1'b0 || phase_valid !== 1'b0) begin
      bad++; $display("FAIL midrst_ignore got fault=%0d valid=%0d exp 0 0", fault, phase_valid);
    end
    step(G); step(G);
    total++; if (phase_valid !== 1'b1 || dwell !== CNT_W'(1)) begin
      bad++; $display("FAIL midrst_resync got valid=%0d dwell=%0d exp 1 1", phase_valid, dwell);
    end
  endtask

  task automatic test_random();
    logic [2:0] codes [3] = '{G, Y, R};
    int p = 0;
    int hold = GREEN_LEN;
    int jit;
    logic [2:0] l;
    logic c, r;
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 99) < 3) begin
        l = 3'($urandom_range(0, 7));
      end else begin
        if (hold == 0) begin
          p = ($urandom_range(0, 49) == 0) ? (p + 2) % 3 : (p + 1) % 3;
          jit = ($urandom_range(0, 9) < 8) ? 0 : (($urandom_range(0, 1) == 1) ? 1 : -1);
          hold = lens[p] + jit;
        end
        l = codes[p];
        hold--;
      end
      c = ($urandom_range(0, 19) == 0);
      r = ($urandom_range(0, 299) != 0);
      step(l, c, r);
      total++;
      if (fault !== (m_mode == 2) || phase_valid !== (m_mode == 1) || fault_code !== 3'(m_code) ||
          dwell !== CNT_W'(m_dwell) || cycle_done !== m_done || cycle_count !== 16'(m_count) ||
          (m_mode == 1 && phase !== 2'(m_ph))) begin
        bad++;
        $display("FAIL rand_%0d got f=%0d v=%0d c=%0d d=%0d done=%0d n=%0d ph=%0d exp f=%0d v=%0d c=%0d d=%0d done=%0d n=%0d ph=%0d",
                 n, fault, phase_valid, fault_code, dwell, cycle_done, cycle_count, phase,
                 m_mode == 2, m_mode == 1, m_code, m_dwell, m_done, m_count, m_ph);
      end
    end
  endtask

  initial begin
    test_reset();
    test_normal_cycles();
    test_illegal();
    test_order_dwell();
    test_clear();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
